seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Request/result handshake bundle for seq_divider.
// The master drives requests and result acceptance; the slave is the divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_div_by_zero;

  modport master (
    output i_valid, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero
  );

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_quotient, o_remainder, o_div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// with optional two's-complement sign correction applied on the final step.
module seq_divider #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input logic          i_clk,
  input logic          i_rst_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             dend_neg, dsor_neg;
  logic [WIDTH-1:0] dend_mag, dsor_mag;
  logic [WIDTH:0]   rem_shift;
  logic             no_borrow;
  logic [WIDTH-1:0] step_rem, step_quo;

  assign accept = bus.i_valid && (state_q == IDLE);

  always_comb begin
    dend_neg = (SIGNED != 1'b0) && bus.i_dividend[WIDTH-1];
    dsor_neg = (SIGNED != 1'b0) && bus.i_divisor[WIDTH-1];
    dend_mag = dend_neg ? ((~bus.i_dividend) + WIDTH'(1)) : bus.i_dividend;
    dsor_mag = dsor_neg ? ((~bus.i_divisor) + WIDTH'(1)) : bus.i_divisor;
  end

  // shf_q shifts dividend bits out at the top while quotient bits enter at the bottom
  always_comb begin
    rem_shift = {rem_q, shf_q[WIDTH-1]};
    no_borrow = (rem_shift >= {1'b0, dvs_q});
    step_rem  = rem_shift[WIDTH-1:0];
    step_quo  = {shf_q[WIDTH-2:0], 1'b0};
    if (no_borrow) begin
      step_rem = rem_shift[WIDTH-1:0] - dvs_q;
      step_quo = {shf_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    shf_d       = shf_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.i_divisor == '0) begin
            quotient_d  = '1;
            remainder_d = bus.i_dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            count_d = '0;
            rem_d   = '0;
            shf_d   = dend_mag;
            dvs_d   = dsor_mag;
            q_neg_d = dend_neg ^ dsor_neg;
            r_neg_d = dend_neg;
            dbz_d   = 1'b0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d   = step_rem;
        shf_d   = step_quo;
        count_d = count_q + CNT_W'(1);
        // Final step: results land in the output registers already sign-corrected
        if (count_q == CNT_W'(WIDTH - 1)) begin
          quotient_d  = q_neg_q ? ((~step_quo) + WIDTH'(1)) : step_quo;
          remainder_d = r_neg_q ? ((~step_rem) + WIDTH'(1)) : step_rem;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      shf_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      shf_q       <= shf_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.o_ready       = (state_q == IDLE);
  assign bus.o_valid       = (state_q == DONE);
  assign bus.o_quotient    = quotient_q;
  assign bus.o_remainder   = remainder_q;
  assign bus.o_div_by_zero = dbz_q;

endmodule
